rf_wb_arbiter: RTL and testbench

- Shares the register file's single write port between NUM_REQ writeback requesters (ALU, load unit, mul/div) using round-robin arbitration with a valid/ready handshake.
- The write port stage is registered, so every write reaches the register file exactly 1 cycle after its handshake.
- Also maintains a per-register busy scoreboard: a bit is set when the issue stage allocates rd, and cleared when the write to that register commits.
- Sits between the execute/memory units and the register file write port (write_enable/write_addr/write_data).

---
 rtl/rv_core_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/rf_wb_arbiter.sv | 86 ++++++++
 tb/tb_rf_wb_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_core_pkg.sv
// Shared core types: register-file geometry and writeback request format.
// No logic, so no latency.
// No flow control; the handshake lives in the modules that import this package.
package rv_core_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   // Writeback source index, matching the arbiter's requester ordering
   typedef enum logic [1:0] {
      WB_ALU    = 2'd0,
      WB_LSU    = 2'd1,
      WB_MULDIV = 2'd2
   } wb_src_e;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] addr;
      logic [31:0]           data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter. The scan starts at rr_ptr and wraps.
// The grant is combinational in the same cycle, and the pointer moves past the winner on the next edge.
// A requester is stalled only by losing arbitration. Grants are forced to 0 while reset is high.
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] grant_idx
);

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] idx;
   logic [N-1:0]     grant_raw;
   logic             found;

   // Scan from rr_ptr. The first asserted request wins.
   always_comb begin
      grant_raw = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int off = 0; off < N; off++) begin
         idx = IDX_W'((int'(rr_ptr) + off) % N);
         if (!found && req[idx]) begin
            found          = 1'b1;
            grant_raw[idx] = 1'b1;
            grant_idx      = idx;
         end
      end
   end

   assign grant = reset ? '0 : grant_raw;

   // Every grant is a transfer. Move the pointer to the requester after the winner.
   always_ff @(posedge clk) begin
      if (reset)
         rr_ptr <= '0;
      else if (found)
         rr_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port among the writeback requesters and tracks per-register busy bits.
// Latency: a write reaches rf_write_* exactly 1 cycle after its handshake.
// No backpressure except losing round-robin arbitration. A request to x0 is accepted but never written.
module rf_wb_arbiter
   import rv_core_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int WIDTH   = 32,
   parameter int DEPTH   = NUM_REGS,
   parameter int ADDR_W  = REG_ADDR_W
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*WIDTH-1:0]  req_data,
   input  logic                      issue_valid,
   input  logic [ADDR_W-1:0]         issue_rd,
   output logic                      rf_write_enable,
   output logic [ADDR_W-1:0]         rf_write_addr,
   output logic [WIDTH-1:0]          rf_write_data,
   output logic [DEPTH-1:0]          busy,
   output logic [1:0]                grant_id
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDX_W-1:0] arb_idx;
   wb_req_t          sel;
   wb_src_e          gid_q;
   logic [DEPTH-1:0] busy_nxt;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .req       (req_valid),
      .grant     (req_ready),
      .grant_idx (arb_idx)
   );

   // Mux out the winning request. A transfer happens whenever any ready bit is set.
   always_comb begin
      sel.valid = |req_ready;
      sel.addr  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
      sel.data  = req_data[int'(arb_idx)*WIDTH +: WIDTH];
   end

   // Register the accepted write. x0 is dropped at the enable, and addr/data hold when idle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rf_write_enable <= 1'b0;
         rf_write_addr   <= '0;
         rf_write_data   <= '0;
         gid_q           <= WB_ALU;
      end else if (sel.valid) begin
         rf_write_enable <= (sel.addr != '0);
         rf_write_addr   <= sel.addr;
         rf_write_data   <= sel.data;
         gid_q           <= wb_src_e'(arb_idx);
      end else begin
         rf_write_enable <= 1'b0;
      end
   end

   assign grant_id = gid_q;

   // Committing write clears its bit and a new allocation sets one. Set is applied last so the newer producer wins.
   always_comb begin
      busy_nxt = busy;
      if (rf_write_enable)
         busy_nxt[rf_write_addr] = 1'b0;
      if (issue_valid && (issue_rd != '0))
         busy_nxt[issue_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end

   // Scoreboard state
   always_ff @(posedge clk) begin
      if (reset)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter. Expected outputs come from a reference model and go into a queue at the drive cycle.
// They are popped and compared one cycle later.
// Requesters are driven by the bench.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        rf_write_enable;
   logic [4:0]  rf_write_addr;
   logic [31:0] rf_write_data;
   logic [31:0] busy;
   logic [1:0]  grant_id;

   logic [4:0]  ad [3];
   logic [31:0] dt [3];

   assign req_addr = {ad[2], ad[1], ad[0]};
   assign req_data = {dt[2], dt[1], dt[0]};

   always #5 clk = ~clk;

   rf_wb_arbiter dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_addr        (req_addr),
      .req_data        (req_data),
      .issue_valid     (issue_valid),
      .issue_rd        (issue_rd),
      .rf_write_enable (rf_write_enable),
      .rf_write_addr   (rf_write_addr),
      .rf_write_data   (rf_write_data),
      .busy            (busy),
      .grant_id        (grant_id)
   );

   typedef struct {
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      logic [1:0]  gid;
      logic [31:0] bsy;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   int          m_ptr = 0;
   logic        m_we  = 1'b0;
   logic [4:0]  m_a   = '0;
   logic [31:0] m_d   = '0;
   logic [1:0]  m_gid = '0;
   logic [31:0] m_busy = '0;
   int          acc_cnt [3];
   logic [2:0]  last_ready;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle with the currently driven inputs. Checks ready before the edge and the registered outputs after it.
   task automatic cyc();
      int   g;
      logic [2:0] m_ready;
      exp_t e;
      @(negedge clk);
      g = -1;
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (g < 0 && req_valid[i]) g = i;
         end
      end
      m_ready = (g >= 0) ? (3'b001 << g) : 3'b000;
      chk("req_ready", 64'(req_ready), 64'(m_ready));
      last_ready = req_ready;
      if (g >= 0) acc_cnt[g]++;
      if (reset) begin
         e.we = 1'b0; e.a = '0; e.d = '0; e.gid = '0; e.bsy = '0;
      end else begin
         if (g >= 0) begin
            e.we = (ad[g] != 5'd0); e.a = ad[g]; e.d = dt[g]; e.gid = 2'(g);
         end else begin
            e.we = 1'b0; e.a = m_a; e.d = m_d; e.gid = m_gid;
         end
         e.bsy = m_busy;
         if (m_we) e.bsy[m_a] = 1'b0;
         if (issue_valid && issue_rd != 5'd0) e.bsy[issue_rd] = 1'b1;
         e.bsy[0] = 1'b0;
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      e = q.pop_front();
      chk("rf_write_enable", 64'(rf_write_enable), 64'(e.we));
      chk("rf_write_addr",   64'(rf_write_addr),   64'(e.a));
      chk("rf_write_data",   64'(rf_write_data),   64'(e.d));
      chk("grant_id",        64'(grant_id),        64'(e.gid));
      chk("busy",            64'(busy),            64'(e.bsy));
      m_we = e.we; m_a = e.a; m_d = e.d; m_gid = e.gid; m_busy = e.bsy;
      if (reset) m_ptr = 0;
      else if (g >= 0) m_ptr = (g + 1) % 3;
   endtask

   task automatic idle_inputs();
      req_valid = '0; issue_valid = 1'b0; issue_rd = '0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         ad[i] = '0; dt[i] = '0; acc_cnt[i] = 0;
      end
      idle_inputs();
      reset = 1'b1;
      cyc(); cyc();
      chk("reset_we", 64'(rf_write_enable), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      reset = 1'b0;

      // Allocate x5, then write it back from the ALU
      issue_valid = 1'b1; issue_rd = 5'd5;
      cyc();
      chk("busy_x5_set", 64'(busy), 64'h20);
      idle_inputs();
      req_valid = 3'b001; ad[0] = 5'd5; dt[0] = 32'hDEADBEEF;
      cyc();
      chk("alu_ready", 64'(last_ready), 64'd1);
      chk("alu_we", 64'(rf_write_enable), 64'd1);
      chk("alu_data", 64'(rf_write_data), 64'hDEADBEEF);
      idle_inputs();
      cyc();
      chk("busy_x5_clear", 64'(busy), 64'd0);

      // Return rr_ptr to 0 via reset, then hold all three requesters valid
      reset = 1'b1; cyc(); reset = 1'b0;
      for (int i = 0; i < 3; i++) acc_cnt[i] = 0;
      for (int s = 0; s < 6; s++) begin
         req_valid = 3'b111;
         for (int i = 0; i < 3; i++) begin
            ad[i] = 5'(10 + i); dt[i] = 32'(s * 16 + i) ^ 32'hC0DE0000;
         end
         cyc();
         chk("rr_order", 64'(last_ready), 64'(3'b001 << (s % 3)));
      end
      for (int i = 0; i < 3; i++) chk($sformatf("accept_count_%0d", i), 64'(acc_cnt[i]), 64'd2);
      idle_inputs();
      cyc();

      // LSU only, writing to x0
      req_valid = 3'b010; ad[1] = 5'd0; dt[1] = 32'h12345678;
      cyc();
      chk("lsu_ready", 64'(last_ready), 64'd2);
      chk("x0_no_we", 64'(rf_write_enable), 64'd0);
      chk("x0_gid", 64'(grant_id), 64'd1);
      idle_inputs();

      // Set and clear of x7 in the same cycle: set wins
      issue_valid = 1'b1; issue_rd = 5'd7;
      cyc();
      idle_inputs();
      req_valid = 3'b001; ad[0] = 5'd7; dt[0] = 32'h0000_0777;
      cyc();
      idle_inputs();
      issue_valid = 1'b1; issue_rd = 5'd7;
      cyc();
      chk("x7_set_wins", 64'(busy[7]), 64'd1);
      idle_inputs();

      // MULDIV accepted, then reset before it commits
      req_valid = 3'b100; ad[2] = 5'd9; dt[2] = 32'hA5A5A5A5;
      cyc();
      idle_inputs();
      reset = 1'b1;
      cyc();
      chk("reset_drop_we", 64'(rf_write_enable), 64'd0);
      chk("reset_drop_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      req_valid = 3'b111;
      cyc();
      chk("post_reset_grant0", 64'(last_ready), 64'd1);
      idle_inputs();

      // issue_rd = 0 is ignored
      issue_valid = 1'b1; issue_rd = 5'd0;
      cyc();
      idle_inputs();
      cyc();
      chk("x0_never_busy", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
